// File: rtl/i2c_poll_sequencer.sv
// rtl/i2c_poll_sequencer.sv - periodic Avalon-MM master reading a sensor burst through the I2C bridge
module i2c_poll_sequencer #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h28,
  parameter int         NUM_BYTES   = 4,
  parameter int         POLL_PERIOD = 50000,
  parameter int         TIMEOUT     = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [2:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic [31:0] sample_data,
  output logic        sample_valid,
  output logic [15:0] nack_count,
  output logic        timeout_err
);
  localparam int PW = $clog2(POLL_PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, W_ADDR, W_RW, W_NB, W_ENA, R_ACK, R_USED, R_DATA} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] per_cnt;
  logic [TW-1:0] to_cnt;
  logic          tick, req, done, to_hit;

  assign tick   = enable && (per_cnt == PW'(POLL_PERIOD - 1));
  assign req    = m_write | m_read;
  assign done   = req && !m_waitrequest;
  assign to_hit = req && m_waitrequest && (to_cnt == TW'(TIMEOUT - 1));

  // Bus command is a pure function of state, so it stays stable while stalled.
  always_comb begin
    m_address   = 3'd0;
    m_write     = 1'b0;
    m_writedata = 32'd0;
    m_read      = 1'b0;
    case (state)
      W_ADDR: begin m_address = 3'd0; m_write = 1'b1; m_writedata = {25'd0, SLAVE_ADDR}; end
      W_RW:   begin m_address = 3'd2; m_write = 1'b1; m_writedata = 32'd1; end
      W_NB:   begin m_address = 3'd4; m_write = 1'b1; m_writedata = 32'(NUM_BYTES); end
      W_ENA:  begin m_address = 3'd3; m_write = 1'b1; m_writedata = 32'd1; end
      R_ACK:  begin m_address = 3'd5; m_read = 1'b1; end
      R_USED: begin m_address = 3'd6; m_read = 1'b1; end
      R_DATA: begin m_address = 3'd1; m_read = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (tick) state_nxt = W_ADDR;
    end else if (to_hit) begin
      state_nxt = IDLE;
    end else if (done) begin
      case (state)
        W_ADDR:  state_nxt = W_RW;
        W_RW:    state_nxt = W_NB;
        W_NB:    state_nxt = W_ENA;
        W_ENA:   state_nxt = R_ACK;
        R_ACK:   state_nxt = m_readdata[0] ? IDLE : R_USED;
        R_USED:  state_nxt = (m_readdata[7:0] == 8'd0) ? IDLE : R_DATA;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      per_cnt      <= '0;
      to_cnt       <= '0;
      sample_data  <= 32'd0;
      sample_valid <= 1'b0;
      nack_count   <= 16'd0;
      timeout_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      // Ticks landing mid-poll are simply lost; IDLE only reacts to a live tick.
      if (!enable || tick) per_cnt <= '0;
      else                 per_cnt <= per_cnt + PW'(1);
      if (req && m_waitrequest && !to_hit) to_cnt <= to_cnt + TW'(1);
      else                                 to_cnt <= '0;
      sample_valid <= (state == R_DATA) && done;
      if ((state == R_DATA) && done) sample_data <= m_readdata;
      if ((state == R_ACK) && done && m_readdata[0] && (nack_count != 16'hFFFF))
        nack_count <= nack_count + 16'd1;
      if (to_hit) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// tb/tb_i2c_poll_sequencer.sv - randomized bench with a transaction-level bridge model for i2c_poll_sequencer
module tb_i2c_poll_sequencer;
  localparam int PERIOD = 32;
  localparam int TMO    = 64;
  localparam int NP     = 16;

  typedef struct {bit ack; bit [7:0] usedw; bit [31:0] word; bit [2:0] stall_addr; int stall_len;} knob_t;
  typedef struct {int idx; logic [35:0] enc;} acc_t;
  typedef struct {int idx; logic [31:0] data;} smp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  m_address;
  logic        m_write, m_read;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = 32'd0;
  logic        m_waitrequest = 1'b0;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic [15:0] nack_count;
  logic        timeout_err;

  i2c_poll_sequencer #(.POLL_PERIOD(PERIOD), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata), .m_read(m_read),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .nack_count(nack_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level model of one poll under a given bridge behaviour.
  function automatic int tmo_idx(knob_t k);
    return (k.stall_addr == 3'd3) ? 3 : (k.stall_addr == 3'd5) ? 4 : -1;
  endfunction
  function automatic bit timed_out(knob_t k);
    return (tmo_idx(k) >= 0) && (k.stall_len >= TMO);
  endfunction
  function automatic int n_acc(knob_t k);
    if (timed_out(k)) return tmo_idx(k);
    return k.ack ? 5 : ((k.usedw == 8'd0) ? 6 : 7);
  endfunction
  function automatic int poll_len(knob_t k);
    if (timed_out(k)) return tmo_idx(k) + TMO;
    return n_acc(k) + ((tmo_idx(k) >= 0) ? k.stall_len : 0);
  endfunction
  function automatic logic [35:0] exp_enc(int j);
    case (j)
      0:       return {1'b1, 3'd0, 32'h0000_0028};
      1:       return {1'b1, 3'd2, 32'h0000_0001};
      2:       return {1'b1, 3'd4, 32'h0000_0004};
      3:       return {1'b1, 3'd3, 32'h0000_0001};
      4:       return {1'b0, 3'd5, 32'h0};
      5:       return {1'b0, 3'd6, 32'h0};
      default: return {1'b0, 3'd1, 32'h0};
    endcase
  endfunction

  knob_t plan[$];
  int    start_log[$];
  acc_t  acc_log[$];
  smp_t  smp_log[$];
  int    drop_log[$];
  int    unstable = 0;
  int    proto_err = 0;

  // Bridge slave model plus bus monitor, evaluated between clock edges.
  initial begin
    knob_t       cur;
    int          poll_idx, stall_left, stall_run;
    bit          req, prev_req, stalled_prev, prev_sv;
    logic [15:0] prev_nack;
    logic [36:0] prev_cmd;
    cur = '{1'b0, 8'd0, 32'd0, 3'd7, 0};
    poll_idx = -1; stall_left = 0; stall_run = 0;
    prev_req = 0; stalled_prev = 0; prev_sv = 0; prev_nack = 16'd0; prev_cmd = '0;
    forever begin
      @(negedge clk);
      req = m_read | m_write;
      if (!reset_n) begin
        prev_req = 0; stalled_prev = 0; stall_run = 0; prev_sv = 0; prev_nack = 16'd0;
        m_waitrequest = 1'b0;
      end else begin
        if (m_read && m_write) proto_err++;
        if (!m_write && m_writedata != 32'd0) proto_err++;
        if (stalled_prev) begin
          if (req && ({m_read, m_write, m_address, m_writedata} != prev_cmd)) unstable++;
          if (!req) drop_log.push_back(stall_run);
        end
        if (m_write && m_address == 3'd0 && !prev_req) begin
          start_log.push_back(cyc);
          poll_idx = start_log.size() - 1;
          if (plan.size() > 0) cur = plan.pop_front();
          else cur = '{1'b0, 8'd0, 32'd0, 3'd7, 0};
          stall_left = cur.stall_len;
        end
        if (req && m_address == cur.stall_addr && stall_left > 0) begin
          m_waitrequest = 1'b1;
          stall_left--;
        end else begin
          m_waitrequest = 1'b0;
        end
        case (m_address)
          3'd5:    m_readdata = {cur.word[31:1], cur.ack};
          3'd6:    m_readdata = {cur.word[31:8], cur.usedw};
          3'd1:    m_readdata = cur.word;
          default: m_readdata = 32'd0;
        endcase
        stall_run = (req && m_waitrequest) ? stall_run + 1 : 0;
        if (req && !m_waitrequest)
          acc_log.push_back('{poll_idx, {m_write, m_address, m_write ? m_writedata : 32'd0}});
        if (sample_valid) begin
          if (prev_sv) proto_err++;
          if (nack_count != prev_nack) proto_err++;
          smp_log.push_back('{poll_idx, sample_data});
        end
        prev_sv = sample_valid;
        prev_nack = nack_count;
        prev_req = req;
        stalled_prev = req && m_waitrequest;
        prev_cmd = {m_read, m_write, m_address, m_writedata};
      end
    end
  end

  initial begin
    knob_t       sched [NP];
    knob_t       k;
    smp_t        exp_smp[$];
    smp_t        obs_smp[$];
    int          rel, p, got, n, exp_nack, n_tmo, n0, r;
    logic [31:0] last_word;

    repeat (3) @(negedge clk);
    check("rst_req", {m_read, m_write}, 0);
    check("rst_addr_wdata", {m_address, m_writedata}, 0);
    check("rst_sample", {sample_valid, sample_data}, 0);
    check("rst_nack", nack_count, 0);
    check("rst_timeout", timeout_err, 0);

    sched[0] = '{1'b0, 8'd1, 32'hA1B2_C3D4, 3'd7, 0};
    sched[1] = '{1'b0, 8'd2, 32'h1234_5678, 3'd5, TMO - 1};
    sched[2] = '{1'b1, 8'd1, 32'hDEAD_0001, 3'd7, 0};
    sched[3] = '{1'b1, 8'd1, 32'hDEAD_0002, 3'd7, 0};
    sched[4] = '{1'b1, 8'd1, 32'hDEAD_0003, 3'd7, 0};
    sched[5] = '{1'b0, 8'd0, 32'hFFFF_FF00, 3'd7, 0};
    sched[6] = '{1'b0, 8'd1, 32'h0BAD_F00D, 3'd3, 1000};
    sched[7] = '{1'b0, 8'd3, 32'h7777_8888, 3'd7, 0};
    for (int i = 8; i < NP; i++) begin
      k.ack = ($urandom_range(0, 3) == 0);
      k.usedw = 8'($urandom_range(0, 3));
      k.word = $urandom();
      r = $urandom_range(0, 2);
      k.stall_addr = (r == 0) ? 3'd3 : (r == 1) ? 3'd5 : 3'd7;
      k.stall_len = $urandom_range(0, 70);
      sched[i] = k;
    end
    for (int i = 0; i < NP; i++) plan.push_back(sched[i]);

    reset_n = 1'b1;
    enable = 1'b1;
    rel = cyc;
    for (int c = 0; c < 20000 && start_log.size() < NP + 1; c++) @(negedge clk);
    check("polls_started", start_log.size() >= NP + 1, 1);

    if (start_log.size() >= NP + 1) begin
      check("first_start", start_log[0] - rel, PERIOD);
      p = 0; exp_nack = 0; n_tmo = 0; last_word = 32'd0;
      for (int i = 0; i < NP; i++) begin
        k = sched[i];
        check($sformatf("gap p%0d", i), start_log[i + 1] - start_log[i],
              PERIOD * ((poll_len(k) + PERIOD) / PERIOD));
        n = n_acc(k);
        got = 0;
        while (p < acc_log.size() && acc_log[p].idx < i) p++;
        while (p < acc_log.size() && acc_log[p].idx == i) begin
          if (got < n) check($sformatf("acc p%0d #%0d", i, got), acc_log[p].enc, exp_enc(got));
          got++; p++;
        end
        check($sformatf("acc_count p%0d", i), got, n);
        if (timed_out(k)) n_tmo++;
        else if (k.ack) exp_nack++;
        else if (k.usedw != 8'd0) begin
          exp_smp.push_back('{i, k.word});
          last_word = k.word;
        end
      end
      foreach (smp_log[j]) if (smp_log[j].idx < NP) obs_smp.push_back(smp_log[j]);
      check("sample_count", obs_smp.size(), exp_smp.size());
      for (int j = 0; j < obs_smp.size() && j < exp_smp.size(); j++) begin
        check($sformatf("sample_poll #%0d", j), obs_smp[j].idx, exp_smp[j].idx);
        check($sformatf("sample_data #%0d", j), obs_smp[j].data, exp_smp[j].data);
      end
      check("drop_count", drop_log.size(), n_tmo);
      foreach (drop_log[j]) check($sformatf("drop_len #%0d", j), drop_log[j], TMO);
      check("stable_while_stalled", unstable, 0);
      check("protocol", proto_err, 0);
      check("nack_count", nack_count, exp_nack);
      check("timeout_err", timeout_err, n_tmo > 0);
      check("sample_hold", sample_data, last_word);
    end

    plan.push_back('{1'b0, 8'd1, 32'h5A5A_0F0F, 3'd5, 40});
    for (int c = 0; c < 500 && !(m_read && m_address == 3'd5 && m_waitrequest); c++) @(negedge clk);
    check("reached_r_ack", m_read && m_address == 3'd5 && m_waitrequest, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_req_drop", {m_read, m_write}, 0);
    check("async_bus_zero", {m_address, m_writedata, sample_data}, 0);
    check("async_status_zero", {sample_valid, timeout_err, nack_count}, 0);

    @(negedge clk);
    plan.push_back('{1'b0, 8'd1, 32'hC0FF_EE11, 3'd7, 0});
    n0 = start_log.size();
    reset_n = 1'b1;
    rel = cyc;
    for (int c = 0; c < 200 && start_log.size() <= n0; c++) @(negedge clk);
    check("restart_seen", start_log.size() > n0, 1);
    if (start_log.size() > n0) check("restart_time", start_log[n0] - rel, PERIOD);
    repeat (12) @(negedge clk);
    check("restart_sample", sample_data, 32'hC0FF_EE11);
    check("restart_timeout_clear", timeout_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/i2c_poll_sequencer.md
Name: i2c_poll_sequencer

Overview:
- Autonomous Avalon-MM master that periodically drives the I2C Avalon bridge slave to read a fixed-length register burst from one I2C sensor, with no HPS involvement.
- Sits directly upstream of the bridge, sharing its 3-bit word-addressed slave port through the system interconnect.
- Captures the returned FIFO word and publishes it with a valid strobe.
- Counts NACKs and records waitrequest timeouts.

Parameters:
- SLAVE_ADDR, 7'h28: 7-bit I2C device address written to bridge reg 0.
- NUM_BYTES, 4: byte count written to bridge reg 4; range 1..4.
- POLL_PERIOD, 50000: clocks from the start of one poll to the start of the next; minimum 16.
- TIMEOUT, 100000: maximum consecutive m_waitrequest-high cycles tolerated on one access.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  level; 1 = polling runs
- m_address  out  3  bridge register index
- m_write  out  1  Avalon write request
- m_writedata  out  32  Avalon write data
- m_read  out  1  Avalon read request
- m_readdata  in  32  Avalon read data, zero latency
- m_waitrequest  in  1  Avalon stall
- sample_data  out  32  last good FIFO word
- sample_valid  out  1  one-cycle strobe when sample_data updates
- nack_count  out  16  saturating count of polls that ended with ack_error=1
- timeout_err  out  1  sticky; set on any access timeout

Behaviour:
- Reset values: all outputs 0; state IDLE; period counter 0; timeout counter 0.
- Avalon rules:
  - Only one of m_read/m_write is high at a time.
  - While m_waitrequest=1, address, data and request are held stable.
  - An access completes in the first cycle the request is high and m_waitrequest=0.
  - m_readdata is sampled in that same cycle.
- Period counter:
  - Free-runs while enable=1 and cleared while enable=0.
  - Issues a start tick when it reaches POLL_PERIOD-1, then wraps to 0.
  - A tick that arrives while a poll is in progress is dropped, not queued.
- States and transitions (each write/read state advances on access completion):
  - IDLE: on start tick with enable=1 -> W_ADDR.
  - W_ADDR: write reg0 = SLAVE_ADDR -> W_RW.
  - W_RW: write reg2 = 1 (read) -> W_NB.
  - W_NB: write reg4 = NUM_BYTES -> W_ENA.
  - W_ENA: write reg3 = 1 -> R_ACK.
  - R_ACK: read reg5. The bridge stalls this read until the transfer finishes.
    - If readdata[0]=1: nack_count +1 (saturating at 16'hFFFF) -> IDLE.
    - Otherwise -> R_USED.
  - R_USED: read reg6.
    - If readdata[7:0]=0 -> IDLE, no sample.
    - Otherwise -> R_DATA.
  - R_DATA: read reg1; sample_data <= m_readdata and sample_valid=1 for exactly the following cycle -> IDLE.
- Unused writedata bits are 0. m_writedata is 0 whenever m_write=0.
- Timeout:
  - The counter increments each cycle a request is high with m_waitrequest=1, and clears on completion.
  - At TIMEOUT: drop the request the next cycle, set timeout_err, -> IDLE.
  - timeout_err clears only on reset.
- enable=0 mid-poll: the current poll runs to completion or timeout; no new poll starts.
- Reset mid-access: requests drop immediately (asynchronous). The bridge is responsible for its own recovery.
- A sample_valid strobe and a nack increment never occur in the same cycle.

Test Plan:
- Reset, enable=1, POLL_PERIOD=32, slave model with waitrequest=0 and ack_error=0, usedw=1, FIFO word 32'hA1B2C3D4 -> write sequence (0,7'h28),(2,1),(4,4),(3,1), then reads 5,6,1; sample_data=32'hA1B2C3D4; one sample_valid pulse; next poll starts 32 clocks after the first.
- Model holds waitrequest 200 cycles on the reg5 read -> command stable throughout; completes normally; timeout_err=0.
- ack_error=1 on three consecutive polls -> nack_count=3; no reg6/reg1 reads; no sample_valid.
- usedw=0 -> poll ends after the reg6 read; sample_data unchanged; sample_valid stays 0.
- TIMEOUT=64, waitrequest stuck high during W_ENA -> request drops after 64 stall cycles; timeout_err=1 and stays 1; the next poll starts on schedule.
- Deassert reset_n during R_ACK -> m_read=0 asynchronously; all outputs 0; after release with enable=1, the first poll starts at count POLL_PERIOD-1.
